// File: rtl/nibble_demux_bank.sv
// nibble_demux_bank: registered 1-to-8 nibble distributor.
// Each accepted word is steered into one of eight held channel registers,
// either by the internal auto pointer or by an explicit channel select.
// Once all eight channels have been written in a frame the block reports
// frame_done and refuses further words until frame_ack.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is combinational from state and frame_ack
// (low in FULL, low while frame_ack is high, low in reset). The producer
// holds in_valid/in_data stable until the transfer happens; in_valid has
// no effect while in_ready is low.
module nibble_demux_bank #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [2:0]   in_sel,
    input  logic         auto,
    input  logic         frame_ack,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [W-1:0] y4,
    output logic [W-1:0] y5,
    output logic [W-1:0] y6,
    output logic [W-1:0] y7,
    output logic [7:0]   written,
    output logic [2:0]   ptr,
    output logic         frame_done
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e       state_q;
    logic [W-1:0] y_q [8];
    logic [7:0]   written_q;
    logic [2:0]   ptr_q;

    logic         accept;
    logic [2:0]   tgt;
    logic [7:0]   written_d;

    // Ready only while filling, with no ack/abort pending, and never in reset.
    assign in_ready = rst_n & (state_q == FILL) & ~frame_ack;
    assign accept   = in_valid & in_ready;

    // Target channel and the written mask that an accepted word would produce.
    always_comb begin
        tgt       = auto ? ptr_q : in_sel;
        written_d = written_q | (8'b0000_0001 << tgt);
    end

    // Frame FSM, channel registers, written mask and auto pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            written_q <= 8'h00;
            ptr_q     <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (frame_ack) begin
                        // Abort: forget progress, keep channel data.
                        written_q <= 8'h00;
                        ptr_q     <= 3'd0;
                    end else if (accept) begin
                        y_q[tgt]  <= in_data;
                        written_q <= written_d;
                        if (auto) begin
                            ptr_q <= ptr_q + 3'd1;
                        end
                        if (written_d == 8'hFF) begin
                            state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (frame_ack) begin
                        written_q <= 8'h00;
                        ptr_q     <= 3'd0;
                        state_q   <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign y4         = y_q[4];
    assign y5         = y_q[5];
    assign y6         = y_q[6];
    assign y7         = y_q[7];
    assign written    = written_q;
    assign ptr        = ptr_q;
    assign frame_done = (state_q == FULL);

endmodule

// File: doc/nibble_demux_bank.md
# nibble_demux_bank

Registered 1-to-8 nibble distributor with a valid/ready input handshake. It is the write-side counterpart of the 8-input, 4-bit selector ALU. It accepts a stream of 4-bit words, steers each one into one of eight held output registers (`y0`..`y7`), and tracks which channels have been written. When all eight channels are written, it flags a complete frame and stalls until the frame is acknowledged. The outputs feed the selector's `i0`..`i7` inputs directly.

## Interface
Parameters:
- `W`, 4: data width of each channel.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  W  word to store.
- `in_sel`  in  3  target channel in addressed mode; ignored in auto mode.
- `auto`  in  1  1 = target is the internal pointer `ptr`; 0 = target is `in_sel`.
- `frame_ack`  in  1  consumer has taken the frame; also acts as abort while filling.
- `y0`..`y7`  out  W each  held channel registers.
- `written`  out  8  bit k = 1 when channel k has been written in the current frame.
- `ptr`  out  3  auto-mode write pointer.
- `frame_done`  out  1  level; all 8 channels written; the frame is stable.

## Operation
- Reset (async, `rst_n`=0):
  - state = FILL.
  - `y0`..`y7` = 0, `written` = 0, `ptr` = 0, `frame_done` = 0.
  - `in_ready` = 0 while `rst_n` is low.
- Handshake:
  - A beat is accepted on a rising edge where `in_valid` & `in_ready` = 1.
  - `in_ready` = (state==FILL) & ~`frame_ack`. This is combinational from state and `frame_ack`.
  - A beat never coincides with an ack.
- Target channel:
  - t = `auto` ? `ptr` : `in_sel`.
  - `auto` is sampled per beat, so modes may be mixed within a frame.
- On an accepted beat:
  - `y[t]` <= `in_data`.
  - `written[t]` <= 1.
  - If `auto`=1: `ptr` <= `ptr`+1, mod 8 (7 wraps to 0).
  - If `auto`=0: `ptr` is unchanged.
- Overwrite of an already-written channel:
  - Data is replaced.
  - `written` is unchanged.
  - The frame does not complete early.
- State FILL:
  - If an accepted beat makes `written` == 8'hFF, go to FULL.
  - If `frame_ack`=1 (abort): `written` <= 0, `ptr` <= 0. `y*` are kept. Stay in FILL.
- State FULL:
  - `frame_done`=1, `in_ready`=0.
  - `y*` and `written` are frozen.
  - If `frame_ack`=1: `written` <= 0, `ptr` <= 0, go to FILL.
- `y*` are never cleared except by reset. Stale values persist into the next frame until overwritten.
- `in_valid` held while `in_ready`=0 (FULL state or ack asserted): no change to any register, no data loss. The producer must hold the word.

## Timing
- Write latency: a word accepted at edge n is visible on `y[t]`, `written[t]`, and `ptr` after edge n.
- Frame completion: the 8th distinct-channel beat is accepted at edge n. `frame_done`=1 and `in_ready`=0 from edge n onward. There is no extra cycle.
- Ack latency: `frame_ack` sampled at edge m in FULL gives `frame_done`=0, `written`=0, `ptr`=0, and `in_ready`=1 (if `frame_ack` is low) after edge m.
- Back-to-back: one beat per cycle is sustained in FILL. A full auto-mode frame takes exactly 8 consecutive accepted cycles.
- Reset mid-frame: all registers clear asynchronously. The first beat after `rst_n` rises goes to channel 0 in auto mode.

## Test plan
- Auto fill:
  - Stimulus: after reset, `auto`=1, `in_valid`=1 for 8 cycles with data 1,2,4,8,C,A,6,F.
  - Required response: after the 8th edge, `y0`..`y7` = 1,2,4,8,C,A,6,F; `written`=FF; `frame_done`=1; `in_ready`=0; `ptr`=0 (wrapped).
- Stall and ack:
  - Stimulus: in FULL, hold `in_valid`=1 with data 5 for 3 cycles, then pulse `frame_ack` for 1 cycle.
  - Required response: `y*` unchanged during the stall; after the ack edge, `frame_done`=0, `written`=00, `in_ready`=1; the next beat (5) lands in `y0`.
- Addressed writes with overwrite:
  - Stimulus: `auto`=0; write `in_sel`=3 data 9, then `in_sel`=3 data 7, then channels 0,1,2,4,5,6,7.
  - Required response: `frame_done` stays 0 until the 9th beat; `y3`=7; `ptr` stays 0 throughout.
- Abort mid-fill:
  - Stimulus: 3 auto beats, then `frame_ack`=1 with `in_valid`=1 in the same cycle.
  - Required response: `in_ready`=0 that cycle and the beat is not taken; afterwards `written`=00, `ptr`=0, `y0`..`y2` keep their values.
- Async reset:
  - Stimulus: drop `rst_n` between clock edges in mid-frame.
  - Required response: all `y*`, `written`, `ptr`, and `frame_done` go to 0 immediately with no clock edge.
- Mixed modes:
  - Stimulus: auto beat (to ch0), addressed beat to ch5, auto beat.
  - Required response: the second auto beat lands in ch1; `ptr`=2; `written`=8'b0010_0011.
